pipe_stage_reg: RTL and testbench

- Generic parametrised pipeline stage register; successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque datapath payload plus a control bundle between stages, using valid/ready handshake.
- Supports stall (backpressure), flush (bubble insertion) and an optional 2-entry skid buffer so in_ready is registered.
- Counts stall cycles for performance analysis.

---
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush, optional
// 2-entry skid buffer (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [STAT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        StEmpty,
        StBusy,
        StFull
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [STAT_W-1:0]   stall_q, stall_d;
    logic                in_xfer;

    // With the skid buffer, in_ready depends only on state; without it, it looks through.
    if (SKID != 0) begin : g_skid
        assign in_ready_o = (state_q != StFull);
    end else begin : g_noskid
        assign in_ready_o = out_ready_i || (state_q == StEmpty);
    end

    assign out_valid_o    = (state_q != StEmpty);
    assign out_data_o     = main_data_q;
    assign out_ctrl_o     = out_valid_o ? main_ctrl_q : '0;
    assign stall_cycles_o = stall_q;
    assign in_xfer        = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    main_data_d = in_data_i;
                    main_ctrl_d = in_ctrl_i;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (in_xfer && out_ready_i) begin
                    main_data_d = in_data_i;
                    main_ctrl_d = in_ctrl_i;
                end else if (in_xfer) begin
                    // Only reachable with SKID=1: main is stalled, park the new entry.
                    skid_data_d = in_data_i;
                    skid_ctrl_d = in_ctrl_i;
                    state_d     = StFull;
                end else if (out_ready_i) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_ready_i) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    state_d     = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush_i) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid_o && !out_ready_i && (stall_q != {STAT_W{1'b1}})) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/STAT_W=4 and a SKID=0/STAT_W=16 instance share stimulus,
// each checked every cycle against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          in_ready_s1, out_valid_s1;
    logic [DW-1:0] out_data_s1;
    logic [CW-1:0] out_ctrl_s1;
    logic [3:0]    stall_s1;

    logic          in_ready_s0, out_valid_s0;
    logic [DW-1:0] out_data_s0;
    logic [CW-1:0] out_ctrl_s0;
    logic [15:0]   stall_s0;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: queue of {data, ctrl} entries held by each stage, plus stall counts.
    logic [DW+CW-1:0] q1[$];
    logic [DW+CW-1:0] q0[$];
    int               cnt1 = 0;
    int               cnt0 = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .STAT_W(4)) u_dut_s1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready_s1),
        .in_data_i      (in_data),
        .in_ctrl_i      (in_ctrl),
        .out_valid_o    (out_valid_s1),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data_s1),
        .out_ctrl_o     (out_ctrl_s1),
        .stall_cycles_o (stall_s1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .STAT_W(16)) u_dut_s0 (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready_s0),
        .in_data_i      (in_data),
        .in_ctrl_i      (in_ctrl),
        .out_valid_o    (out_valid_s0),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data_s0),
        .out_ctrl_o     (out_ctrl_s0),
        .stall_cycles_o (stall_s0)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    always @(posedge clk) begin
        bit acc1, acc0;
        if (rst) begin
            q1.delete();
            q0.delete();
            cnt1 = 0;
            cnt0 = 0;
        end else begin
            acc1 = in_valid && (q1.size() < 2);
            acc0 = in_valid && (out_ready || q0.size() == 0);
            if (q1.size() > 0 && !out_ready && cnt1 < 15) cnt1++;
            if (q0.size() > 0 && !out_ready && cnt0 < 65535) cnt0++;
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (acc1) q1.push_back({in_data, in_ctrl});
            if (acc0) q0.push_back({in_data, in_ctrl});
            if (flush) begin
                q1.delete();
                q0.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("s1_in_ready", 128'(in_ready_s1), 128'(q1.size() < 2));
            check_eq("s1_out_valid", 128'(out_valid_s1), 128'(q1.size() > 0));
            check_eq("s1_stall", 128'(stall_s1), 128'(cnt1));
            if (q1.size() > 0) begin
                check_eq("s1_out_data", 128'(out_data_s1), 128'(q1[0][DW+CW-1:CW]));
                check_eq("s1_out_ctrl", 128'(out_ctrl_s1), 128'(q1[0][CW-1:0]));
            end else begin
                check_eq("s1_bubble_ctrl", 128'(out_ctrl_s1), 128'(0));
            end
            check_eq("s0_in_ready", 128'(in_ready_s0), 128'(out_ready || q0.size() == 0));
            check_eq("s0_out_valid", 128'(out_valid_s0), 128'(q0.size() > 0));
            check_eq("s0_stall", 128'(stall_s0), 128'(cnt0));
            if (q0.size() > 0) begin
                check_eq("s0_out_data", 128'(out_data_s0), 128'(q0[0][DW+CW-1:CW]));
                check_eq("s0_out_ctrl", 128'(out_ctrl_s0), 128'(q0[0][CW-1:0]));
            end else begin
                check_eq("s0_bubble_ctrl", 128'(out_ctrl_s0), 128'(0));
            end
        end
    end

    task automatic step(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                        input logic o);
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = d[CW-1:0] ^ 8'hA5;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk_en = 1'b1;
        check_eq("rst_data_s1", 128'(out_data_s1), 128'(0));
        check_eq("rst_data_s0", 128'(out_data_s0), 128'(0));

        // Stream 1..10 at full rate.
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check_eq("stream_stall", 128'(stall_s1), 128'(0));

        // Backpressure: three stalled cycles after entry 1 is presented.
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b1, DW'(1), 1'b1);
        step(1'b0, 1'b0, 1'b1, DW'(2), 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'(3), 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'(3), 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'(3), 1'b1);
        step(1'b0, 1'b0, 1'b1, DW'(3), 1'b1);
        step(1'b0, 1'b0, 1'b1, DW'(4), 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check_eq("bp_stall_s1", 128'(stall_s1), 128'(3));

        // Flush while FULL, with a new input on the flush edge.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'('hA), 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'('hB), 1'b0);
        step(1'b0, 1'b1, 1'b1, DW'('hC), 1'b0);
        check_eq("flush_valid", 128'(out_valid_s1), 128'(0));
        check_eq("flush_ctrl", 128'(out_ctrl_s1), 128'(0));
        check_eq("flush_ready", 128'(in_ready_s1), 128'(1));
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check_eq("flush_no_emit", 128'(out_valid_s1), 128'(0));

        // Counter saturation on the 4-bit instance.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'(7), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("sat_stall_s1", 128'(stall_s1), 128'(15));
        check_eq("nosat_stall_s0", 128'(stall_s0), 128'(20));
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check_eq("flush_keeps_stall", 128'(stall_s1), 128'(15));

        // Reset mid-stall while FULL.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'('h21), 1'b0);
        step(1'b0, 1'b0, 1'b1, DW'('h22), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check_eq("pre_rst_stall", 128'(stall_s1), 128'(5));
        step(1'b1, 1'b0, 1'b1, DW'('h23), 1'b1);
        check_eq("rst_valid", 128'(out_valid_s1), 128'(0));
        check_eq("rst_stall", 128'(stall_s1), 128'(0));
        check_eq("rst_ready", 128'(in_ready_s1), 128'(1));

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 7), {$urandom, $urandom, $urandom},
                 ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
